// File: rtl/i2s_transmitter.sv
// Philips I2S master transmitter: 64 BCLK frames (32 per slot), MSB one BCLK after each LRCLK edge.
// All outputs registered; the sample pair is captured on sample_valid_in and loaded at frame start.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic [SAMPLE_WIDTH-1:0] left_sample_in,
  input  logic [SAMPLE_WIDTH-1:0] right_sample_in,
  input  logic                    sample_valid_in,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  localparam int              DW       = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [5:0]      SW_BITS  = 6'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0]           div_cnt;
  logic [DW-1:0]           div_cnt_nxt;
  logic [5:0]              bit_cnt;
  logic [5:0]              bit_cnt_nxt;
  logic [5:0]              bit_inc;
  logic [4:0]              slot_pos;
  logic [SAMPLE_WIDTH-1:0] hold_l;
  logic [SAMPLE_WIDTH-1:0] hold_r;
  logic [SAMPLE_WIDTH-1:0] shift_l;
  logic [SAMPLE_WIDTH-1:0] shift_r;
  logic [SAMPLE_WIDTH-1:0] shift_l_nxt;
  logic [SAMPLE_WIDTH-1:0] shift_r_nxt;
  logic                    fresh;
  logic                    bclk_nxt;
  logic                    lrclk_nxt;
  logic                    data_nxt;
  logic                    frame_start_nxt;
  logic                    underrun_nxt;
  logic                    active;
  logic                    div_wrap;
  logic                    fall;
  logic                    frame_end;
  logic                    load;

  assign active    = (state != IDLE);
  assign div_wrap  = active && (div_cnt == DIV_LAST);
  assign fall      = div_wrap && i2s_bclk_out;
  assign frame_end = fall && (bit_cnt == 6'd63);
  assign load      = frame_end && enable_in;
  assign bit_inc   = bit_cnt + 6'd1;
  assign slot_pos  = bit_inc[4:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping enable mid-frame drains; the frame always ends on the fall back to bit 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_in) state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (frame_end && !enable_in) state_nxt = IDLE;
        else if (enable_in)          state_nxt = RUN;
        else                         state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_cnt_nxt     = div_cnt;
    bit_cnt_nxt     = bit_cnt;
    bclk_nxt        = i2s_bclk_out;
    lrclk_nxt       = i2s_lrclk_out;
    data_nxt        = i2s_data_out;
    shift_l_nxt     = shift_l;
    shift_r_nxt     = shift_r;
    frame_start_nxt = 1'b0;
    underrun_nxt    = 1'b0;
    if (state == IDLE) begin
      div_cnt_nxt = '0;
      bit_cnt_nxt = 6'd63;
      bclk_nxt    = 1'b0;
      lrclk_nxt   = 1'b0;
      data_nxt    = 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt_nxt = '0;
        bclk_nxt    = !i2s_bclk_out;
      end else begin
        div_cnt_nxt = div_cnt + DW'(1);
      end
      if (frame_end && !enable_in) begin
        bit_cnt_nxt = 6'd63;
        lrclk_nxt   = 1'b0;
        data_nxt    = 1'b0;
      end else if (fall) begin
        bit_cnt_nxt = bit_inc;
        lrclk_nxt   = bit_inc[5];
        data_nxt    = 1'b0;
        if (load) begin
          // A pulse coinciding with the load bypasses the holding register.
          shift_l_nxt     = sample_valid_in ? left_sample_in  : hold_l;
          shift_r_nxt     = sample_valid_in ? right_sample_in : hold_r;
          frame_start_nxt = 1'b1;
          underrun_nxt    = !fresh && !sample_valid_in;
        end else if ((slot_pos != 5'd0) && ({1'b0, slot_pos} <= SW_BITS)) begin
          if (bit_inc[5]) begin
            data_nxt    = shift_r[SAMPLE_WIDTH-1];
            shift_r_nxt = shift_r << 1;
          end else begin
            data_nxt    = shift_l[SAMPLE_WIDTH-1];
            shift_l_nxt = shift_l << 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt         <= '0;
      bit_cnt         <= 6'd63;
      hold_l          <= '0;
      hold_r          <= '0;
      shift_l         <= '0;
      shift_r         <= '0;
      fresh           <= 1'b0;
      i2s_bclk_out    <= 1'b0;
      i2s_lrclk_out   <= 1'b0;
      i2s_data_out    <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
    end else begin
      div_cnt         <= div_cnt_nxt;
      bit_cnt         <= bit_cnt_nxt;
      shift_l         <= shift_l_nxt;
      shift_r         <= shift_r_nxt;
      i2s_bclk_out    <= bclk_nxt;
      i2s_lrclk_out   <= lrclk_nxt;
      i2s_data_out    <= data_nxt;
      frame_start_out <= frame_start_nxt;
      underrun_out    <= underrun_nxt;
      if (sample_valid_in) begin
        hold_l <= left_sample_in;
        hold_r <= right_sample_in;
      end
      if (load) begin
        fresh <= 1'b0;
      end else if (sample_valid_in) begin
        fresh <= 1'b1;
      end
    end
  end

endmodule
